iter_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider; the inverse companion to the single-cycle combinational ALU multiply.
- Computes quotient and remainder for signed or unsigned 32-bit operands.
- Sits beside the ALU in the CPU execute stage. The pipeline stalls on in_ready/out_valid.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/iter_divider_pkg.sv | 14 +
 rtl/iter_divider_div_step.sv | 23 ++
 rtl/iter_divider.sv | 125 ++++++++++++
 tb/tb_iter_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: default width and
// FSM state encodings.
package iter_divider_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module iter_divider_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] r,
  input  logic                  dividend_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] r_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;

  assign shifted = {r, dividend_msb};
  assign q_bit   = (shifted >= {1'b0, divisor});
  // When the subtraction is taken the result is below the divisor, so it
  // always fits in DATA_WIDTH bits and the modulo subtraction is exact.
  assign diff    = shifted[DATA_WIDTH-1:0] - divisor;
  assign r_next  = q_bit ? diff : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider with valid/ready handshakes on both
// sides; one operation in flight, signed or unsigned operands.
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Quotient,
  output logic [DATA_WIDTH-1:0] Remainder,
  output logic                  DivByZero
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  div_state_e state, state_next;

  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [DATA_WIDTH-1:0] rem;
  logic                  sign_q;
  logic                  sign_r;

  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic [DATA_WIDTH-1:0] rem_next;
  logic                  q_bit;
  logic                  accept;
  logic                  b_zero;
  logic                  last_step;

  assign in_ready  = (state == DIV_IDLE);
  assign out_valid = (state == DIV_DONE);
  assign accept    = in_ready && in_valid;
  assign b_zero    = (B == '0);
  assign last_step = (count == CNT_W'(1));

  // Magnitude of the most negative value wraps to itself, which is exactly
  // the unsigned magnitude we need.
  assign a_mag = (is_signed && A[DATA_WIDTH-1]) ? -A : A;
  assign b_mag = (is_signed && B[DATA_WIDTH-1]) ? -B : B;

  iter_divider_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .r           (rem),
    .dividend_msb(dividend[DATA_WIDTH-1]),
    .divisor     (divisor),
    .r_next      (rem_next),
    .q_bit       (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (in_valid)  state_next = b_zero ? DIV_DONE : DIV_ITER;
      DIV_ITER: if (last_step) state_next = DIV_FIX;
      DIV_FIX:                 state_next = DIV_DONE;
      DIV_DONE: if (out_ready) state_next = DIV_IDLE;
      default:                 state_next = DIV_IDLE;
    endcase
  end

  // Architecturally visible state: counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: if (accept) begin
          count <= CNT_W'(DATA_WIDTH);
          if (b_zero) begin
            Quotient  <= '1;
            Remainder <= A;
            DivByZero <= 1'b1;
          end
        end
        DIV_ITER: count <= count - CNT_W'(1);
        DIV_FIX: begin
          Quotient  <= sign_q ? -dividend : dividend;
          Remainder <= sign_r ? -rem : rem;
          DivByZero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the working registers carry no reset; they are always loaded on
  // accept before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      dividend <= a_mag;
      divisor  <= b_mag;
      rem      <= '0;
      sign_q   <= is_signed & (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
      sign_r   <= is_signed & A[DATA_WIDTH-1];
    end else if (state == DIV_ITER) begin
      rem      <= rem_next;
      dividend <= {dividend[DATA_WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed vector table, handshake and
// reset corner sequences, and random operations against an arithmetic model.
module tb_iter_divider;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Quotient;
  logic [DW-1:0] Remainder;
  logic          DivByZero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  iter_divider #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
  // and give the remainder the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
      end
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      dz = 1'b0;
    end
  endfunction

  // Presents one operation and returns at the falling edge right after the
  // accept edge; operands are then scrambled to catch re-sampling.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    A = a; B = b; is_signed = sgn; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; is_signed = ~sgn;
  endtask

  // lat = rising edges after the accept edge before out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("result_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic finish_op(input logic try_new);
    @(negedge clk);
    out_ready = 1'b1;
    if (try_new) begin
      in_valid = 1'b1; A = 32'd50; B = 32'd5;
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                              input logic dz);
    check({tag, "_quotient"}, Quotient, q);
    check({tag, "_remainder"}, Remainder, r);
    check({tag, "_divbyzero"}, 32'(DivByZero), 32'(dz));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    int          lat;
    logic [31:0] eq, er, ra, rb;
    logic        edz, rs;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0});
    vecs.push_back('{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0});
    vecs.push_back('{32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1});
    vecs.push_back('{32'h12345678,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h12345678,   1'b1});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   1'b0});
    vecs.push_back('{32'h80000000,   32'd1,          1'b1, 32'h80000000,   32'd0,          1'b0});
    vecs.push_back('{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0});
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0});
    vecs.push_back('{32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check_result("reset", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;

    // Directed table: nonzero divisors finish 33 edges after accept; a zero
    // divisor completes on the accept edge itself.
    for (int i = 0; i < vecs.size(); i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].sgn);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].b == 0) ? 32'd0 : 32'd33);
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz);
      finish_op(1'b0);
    end

    // Busy-time in_valid is ignored; held result stays stable under backpressure;
    // in_valid during the out_ready handshake is not accepted.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    check("busy_in_ready", 32'(in_ready), 32'd0);
    A = 32'd5; B = 32'd1; is_signed = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    for (int c = 0; c < 10; c++) begin
      check_result($sformatf("hold%0d", c), 32'd14, 32'd2, 1'b0);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("hold_out_valid", 32'(out_valid), 32'd1);
    finish_op(1'b1);
    start_op(32'd9, 32'd3, 1'b1);
    wait_result(lat);
    check("post_handshake_latency", 32'(lat), 32'd33);
    check_result("post_handshake", 32'd3, 32'd0, 1'b0);
    finish_op(1'b0);

    // Reset in the middle of ITER aborts and clears all outputs.
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check_result("midreset", 32'd0, 32'd0, 1'b0);
    start_op(32'd9, 32'd3, 1'b0);
    wait_result(lat);
    check("after_reset_latency", 32'(lat), 32'd33);
    check_result("after_reset", 32'd3, 32'd0, 1'b0);
    finish_op(1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFFFFFF;
        3:       rb = 32'($urandom) >> $urandom_range(1, 31);
        default: rb = 32'($urandom);
      endcase
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, eq, er, edz);
      start_op(ra, rb, rs);
      wait_result(lat);
      check($sformatf("rand%0d_latency", i), 32'(lat), (rb == 0) ? 32'd0 : 32'd33);
      check_result($sformatf("rand%0d", i), eq, er, edz);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finish_op(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
